// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit AXI-lite master:
// FSM state encodings, RISC-V funct3 size codes and the request legality check.
package lsu_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    // RISC-V load/store size codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Returns 1 when a request is misaligned or uses an encoding that is not
    // legal for its direction (unsigned sizes exist only for loads).
    function automatic logic lsu_req_error(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = (addr_lo != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: builds write strobes and lane-replicated
// store data, and extracts/extends load data from the addressed bus word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted_s;

    // Store path: strobe the addressed lanes and copy the datum into every lane
    always_comb begin
        wstrb = 4'b0000;
        wdata = store_data;
        case (funct3)
            F3_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                wstrb = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            F3_W: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Load path: move the addressed byte/half down to bit 0, then extend
    always_comb begin
        shifted_s = bus_rdata >> {addr_lo, 3'b000};
        load_data = 32'h0000_0000;
        case (funct3)
            F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    load_data = shifted_s;
            F3_BU:   load_data = {24'h00_0000, shifted_s[7:0]};
            F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_axi_lite_master.sv
// Load/store unit front end: accepts one core memory request at a time and
// turns it into a single AXI-lite read or write transaction, returning a
// one-cycle completion pulse with extended load data and an error flag.
module lsu_axi_lite_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // core request / response
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    // AXI-lite read address
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    // AXI-lite read data
    input  logic [31:0]           rdata_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    // AXI-lite write address
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    // AXI-lite write data
    output logic [31:0]           wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    // AXI-lite write response
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    logic [2:0]            state_r;
    logic                  we_r;
    logic [2:0]            funct3_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic                  aw_done_r;
    logic                  w_done_r;
    logic [31:0]           rdata_r;
    logic                  err_r;

    logic                  req_err_s;
    logic                  aw_fin_s;
    logic                  w_fin_s;
    logic [3:0]            wstrb_s;
    logic [31:0]           wdata_s;
    logic [31:0]           load_data_s;

    lsu_align u_align (
        .funct3     (funct3_r),
        .addr_lo    (addr_r[1:0]),
        .store_data (wdata_r),
        .bus_rdata  (rdata_i),
        .wstrb      (wstrb_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s)
    );

    assign req_err_s = lsu_req_error(req_we_i, req_funct3_i, req_addr_i[1:0]);

    // A write channel counts as finished once done earlier or handshaking now
    assign aw_fin_s = aw_done_r | awready_i;
    assign w_fin_s  = w_done_r  | wready_i;

    // Request latching, bus sequencing and response capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            we_r      <= 1'b0;
            funct3_r  <= 3'b000;
            addr_r    <= '0;
            wdata_r   <= 32'h0000_0000;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_r      <= req_we_i;
                        funct3_r  <= req_funct3_i;
                        addr_r    <= req_addr_i;
                        wdata_r   <= req_wdata_i;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        rdata_r   <= 32'h0000_0000;
                        err_r     <= req_err_s;
                        // Bad requests complete immediately without touching the bus
                        if (req_err_s) begin
                            state_r <= ST_RSP;
                        end else if (req_we_i) begin
                            state_r <= ST_WR_REQ;
                        end else begin
                            state_r <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready_i) begin
                        state_r <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid_i) begin
                        rdata_r <= load_data_s;
                        state_r <= ST_RSP;
                    end
                end
                ST_WR_REQ: begin
                    if (awready_i) begin
                        aw_done_r <= 1'b1;
                    end
                    if (wready_i) begin
                        w_done_r <= 1'b1;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        state_r <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid_i) begin
                        err_r   <= (bresp_i != 2'b00);
                        state_r <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake signals are pure decodes of registered state, so they stay
    // stable for as long as a channel is waiting on the slave.
    assign req_ready_o = (state_r == ST_IDLE);
    assign rsp_valid_o = (state_r == ST_RSP);
    assign rsp_rdata_o = rdata_r;
    assign rsp_err_o   = err_r;

    assign araddr_o    = {addr_r[ADDR_WIDTH-1:2], 2'b00};
    assign arvalid_o   = (state_r == ST_RD_ADDR);
    assign rready_o    = (state_r == ST_RD_DATA);

    assign awaddr_o    = {addr_r[ADDR_WIDTH-1:2], 2'b00};
    assign awvalid_o   = (state_r == ST_WR_REQ) && !aw_done_r;
    assign wvalid_o    = (state_r == ST_WR_REQ) && !w_done_r;
    assign wdata_o     = wdata_s;
    assign wstrb_o     = wstrb_s;
    assign bready_o    = (state_r == ST_WR_RESP);

endmodule

// File: doc/lsu_axi_lite_master.md
LSU_AXI_LITE_MASTER -- requirements
Module: lsu_axi_lite_master
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width; data width fixed at 32.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state on posedge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  core memory request valid.
REQ-005 SHALL have port req_ready_o  output  1  block can accept a request.
REQ-006 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3_i  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr_i  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data, LSB-aligned.
REQ-010 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata_o  output  32  extended load data; 0 for stores.
REQ-012 SHALL have port rsp_err_o  output  1  misaligned/illegal request or nonzero bresp.
REQ-013 SHALL have AXI-lite master ports araddr_o/arvalid_o out, arready_i in (ADDR_WIDTH,1,1).
REQ-014 SHALL have ports rdata_i in 32, rvalid_i in 1, rready_o out 1.
REQ-015 SHALL have ports awaddr_o out ADDR_WIDTH, awvalid_o out 1, awready_i in 1.
REQ-016 SHALL have ports wdata_o out 32, wstrb_o out 4, wvalid_o out 1, wready_i in 1.
REQ-017 SHALL have ports bresp_i in 2, bvalid_i in 1, bready_o out 1.
Function
REQ-018 SHALL use FSM IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP; req_ready_o = (state==IDLE); one outstanding request only.
REQ-019 SHALL latch we/funct3/addr/wdata on req_valid_i&&req_ready_o; loads -> RD_ADDR, stores -> WR_REQ.
REQ-020 SHALL, for misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal funct3 (011,110,111; 100/101 with store), go IDLE->RSP with rsp_err_o=1 and issue no bus transaction.
REQ-021 SHALL in RD_ADDR drive arvalid_o=1, araddr_o={addr[31:2],2'b00}; on arready_i -> RD_DATA.
REQ-022 SHALL in RD_DATA drive rready_o=1; on rvalid_i capture rdata_i>>(8*addr[1:0]), sign/zero-extend per funct3, -> RSP.
REQ-023 SHALL in WR_REQ hold awvalid_o and wvalid_o high independently until each handshakes (per-channel done flags); both in the same cycle is legal; both done -> WR_RESP.
REQ-024 SHALL drive wstrb_o = 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W); wdata_o replicates byte/half across lanes; awaddr_o word-aligned.
REQ-025 SHALL in WR_RESP drive bready_o=1; on bvalid_i set error = (bresp_i!=0), -> RSP.
REQ-026 SHALL in RSP assert rsp_valid_o exactly one cycle, then IDLE; valid/address/data outputs stable while valid is waiting for ready.
REQ-027 SHALL give rsp_valid_o the cycle after the R or B handshake; zero-wait slave read completes 4 cycles after acceptance.
Reset
REQ-028 SHALL on rst_ni low asynchronously enter IDLE and clear all valid/ready outputs, rsp_rdata_o, rsp_err_o, done flags.
REQ-029 SHALL, if reset occurs mid-transaction, abandon it with no response; bus side is reset together.
Structure
REQ-030 SHALL place the state enum and funct3 encodings in shared package lsu_pkg.
REQ-031 SHALL use one sub-module lsu_align (combinational wstrb/wdata generation and load extraction).
Verification
REQ-032 LB addr 0x80000003, rdata 0x80FF1234 -> araddr 0x80000000, rsp_rdata 0xFFFFFF80, err 0.
REQ-033 LHU addr 0x80000002, rdata 0xBEEF0000 -> rsp_rdata 0x0000BEEF, 4 cycles after accept.
REQ-034 SB addr 0x80000001 wdata 0xAB, awready delayed 3 cycles after wready -> wstrb 0010, wdata 0xABABABAB, one AW, one W.
REQ-035 SW addr 0x80000002 -> rsp_err 1 next-next cycle, no arvalid/awvalid ever high.
REQ-036 SW, bresp 2'b10 -> rsp_err 1; rst_ni low during RD_DATA -> all outputs 0, no rsp_valid.
